sde_c2h_axis: RTL and testbench
===============================

# sde_c2h_axis

Card-to-host AXI-Stream ingress block for the SDE. It accepts packets from the user C2H AXI-Stream port and forwards them through a fully registered skid stage into the C2H data buffer. On the buffer side it attaches each packet's byte length to the last beat, and it maintains the C2H packet counter used by the CSR block and the write-back block.

## Interface
Parameters:
- DESC_TYPE, 0: descriptor type; 0 = Regular, 1 = Compact.
- PCIM_DATA_WIDTH, 512: buffer-side data width.
- AXIS_DATA_WIDTH, 512: user-side data width. Only AXIS_DATA_WIDTH == PCIM_DATA_WIDTH == 512 is supported.
- USER_BIT_WIDTH, DESC_TYPE ? 1 : 64: tuser width.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_axis_clr_pkt_cnt  in  1  synchronous clear of the packet counter.
- axis_cfg_pkt_cnt  out  32  packet counter, read by the CSR block.
- axis_cfg_keep_err  out  1  sticky tkeep-format error flag (see Configuration).
- c2h_axis_valid/data/keep/user/last  in  1/512/64/USER_BIT_WIDTH/1  user stream.
- c2h_axis_ready  out  1  user-side ready.
- axis_buf_valid/data/keep/user/last  out  1/512/64/USER_BIT_WIDTH/1  stream to the buffer.
- axis_buf_len  out  32  packet byte count; valid only when axis_buf_valid & axis_buf_last.
- buf_axis_ready  in  1  buffer-side ready.
- axis_wb_pkt_cnt_req  out  1  one-cycle pulse per completed packet.
- axis_wb_pkt_cnt  out  32  packet counter for write-back.

## Operation
- Skid stage: a main register plus a skid register, each holding data, keep, user, last, and len.
- c2h_axis_ready = !skid_valid, driven straight from a flop, with no combinational path from buf_axis_ready.
- Input accept with the main register empty, or with the main register draining this cycle: the beat loads into the main register.
- Input accept with the main register full and stalled: the beat loads into the skid register.
- On a drain, the skid register moves into the main register.
- Byte accumulator (32 bits): on each input handshake, acc_next = acc + popcount(c2h_axis_keep), where popcount is 0..64.
  - On a last beat, the len field of that beat = acc_next, and acc resets to 0.
  - acc wraps modulo 2^32.
- Packet counter increments on buffer-side handshake with last (axis_buf_valid & buf_axis_ready & axis_buf_last).
  - Wraps 0xFFFFFFFF → 0.
  - cfg_axis_clr_pkt_cnt has priority over increment. If both occur in the same cycle, the result is 0 and that packet is not counted.
- axis_wb_pkt_cnt_req is registered from the same handshake. It pulses even when a clear coincides.
- axis_wb_pkt_cnt = axis_cfg_pkt_cnt = counter register.
- Beats with keep == 0 are accepted and forwarded unchanged, contributing 0 bytes.

## Timing
- Reset values:
  - axis_buf_valid 0, c2h_axis_ready 0 while in reset, then 1 in the first cycle after deassertion.
  - Counters 0, accumulator 0, axis_wb_pkt_cnt_req 0, axis_cfg_keep_err 0.
  - Data, keep, user, last, and len registers also reset to 0.
- Latency: 1 cycle from input handshake to axis_buf_valid when the buffer side is idle.
- Throughput: 1 beat/cycle sustained with buf_axis_ready held high.
- Backpressure: after buf_axis_ready falls, at most 1 further beat is accepted (into the skid register). c2h_axis_ready falls in the following cycle.
- AXI-S rules: once axis_buf_valid is asserted, it and its payload stay stable until buf_axis_ready.
- axis_wb_pkt_cnt_req is asserted in the cycle after the last-beat handshake. In that cycle, axis_wb_pkt_cnt already holds the incremented value.
- Reset mid-packet: all in-flight beats and the partial length are discarded, with no write-back pulse.

## Configuration
- SDE_C2H_AXIS_KEEP_CHK_EN defined: every input handshake checks tkeep.
  - Non-last beats must have keep == all-ones.
  - Last beats must have keep == 2^n−1 with n in 1..64.
  - A violation sets axis_cfg_keep_err in the following cycle. It is cleared only by reset or cfg_axis_clr_pkt_cnt.
  - Data is forwarded unchanged either way.
- Not defined: no check logic is built; axis_cfg_keep_err is tied 0.

## Structure
- sde_pkg holds:
  - SDE_AXIS_DW = 512 and SDE_AXIS_KW = 64.
  - A struct typedef for the beat payload (data, keep, user, last, len). user is sized for the 64-bit case and truncated to USER_BIT_WIDTH at the ports.
  - The popcount function.
- One sub-module: sde_axis_skid. It is a generic 2-entry register slice over a packed payload, with valid/ready on both sides.
- The top level holds the accumulator, counters, and keep check.

## Test plan
- Single 1-beat packet, keep=64'hFFFF_FFFF_FFFF_FFFF, ready high → axis_buf_valid 1 cycle later, axis_buf_len=64; wb_req pulses 1 cycle after the output handshake with pkt_cnt=1.
- 3-beat packet with last keep=64'h0000_0000_0000_00FF → axis_buf_len=136; 100 back-to-back packets give pkt_cnt=100 and no bubbles.
- Hold buf_axis_ready low 5 cycles mid-stream → exactly 2 beats buffered; c2h_axis_ready low from the second stall cycle; no beat lost or duplicated after release.
- Preload counter to 0xFFFF_FFFF via repeated packets (or force) → next packet wraps it to 0; assert clear coincident with a last handshake → count 0, wb_req still pulses.
- Deassert rst_n asynchronously mid-packet → outputs return to their reset values immediately; the next packet's len counts only its own bytes.
- With SDE_C2H_AXIS_KEEP_CHK_EN: non-last beat keep=64'h7FFF…F → axis_cfg_keep_err=1 next cycle, data still forwarded; clear drops it to 0. Without the macro, the flag stays 0.

Source files
------------

// File: rtl/sde_pkg.sv
// Shared widths, beat payload type and keep helpers for the SDE C2H AXI-Stream path.
package sde_pkg;

    localparam int unsigned SDE_AXIS_DW  = 512;
    localparam int unsigned SDE_AXIS_KW  = 64;
    localparam int unsigned SDE_USER_MAX = 64;

    // user is carried at full width internally and truncated at the ports
    typedef struct packed {
        logic [SDE_AXIS_DW-1:0]  data;
        logic [SDE_AXIS_KW-1:0]  keep;
        logic [SDE_USER_MAX-1:0] user;
        logic                    last;
        logic [31:0]             len;
    } sde_beat_t;

    function automatic logic [6:0] sde_popcount(input logic [SDE_AXIS_KW-1:0] keep);
        logic [6:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < SDE_AXIS_KW; i++) begin
            cnt = cnt + 7'(keep[i]);
        end
        return cnt;
    endfunction

    // True for keep == 2^n-1 with n in 1..64
    function automatic logic sde_keep_contig(input logic [SDE_AXIS_KW-1:0] keep);
        return (keep != '0) && ((keep & (keep + 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/sde_c2h_axis_if.sv
// AXI-Stream beat bundle used on both the user side and the buffer side of sde_c2h_axis.
interface sde_c2h_axis_if
    import sde_pkg::*;
#(
    parameter int USER_BIT_WIDTH = 64
);

    logic                      valid;
    logic [SDE_AXIS_DW-1:0]    data;
    logic [SDE_AXIS_KW-1:0]    keep;
    logic [USER_BIT_WIDTH-1:0] user;
    logic                      last;
    logic                      ready;

    modport master (
        output valid, data, keep, user, last,
        input  ready
    );

    modport slave (
        input  valid, data, keep, user, last,
        output ready
    );

endinterface

// File: rtl/sde_axis_skid.sv
// Generic two-entry fully registered slice (main + skid) over a packed payload;
// upstream ready is a flop, so there is no combinational path from m_ready.
module sde_axis_skid #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_payload,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_payload
);

    logic             main_valid;
    logic             skid_valid;
    logic             skid_valid_nxt;
    logic             in_ready;
    logic             in_fire;
    logic             main_free;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign in_fire   = s_valid & in_ready;
    assign main_free = ~main_valid | m_ready;

    always_comb begin
        skid_valid_nxt = skid_valid;
        if (main_free) begin
            skid_valid_nxt = 1'b0;
        end else if (in_fire) begin
            skid_valid_nxt = 1'b1;
        end
    end

    // in_ready tracks !skid_valid, but is held low through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            skid_valid <= skid_valid_nxt;
            in_ready   <= ~skid_valid_nxt;
            if (main_free) begin
                if (skid_valid) begin
                    main_q     <= skid_q;
                    main_valid <= 1'b1;
                end else if (in_fire) begin
                    main_q     <= s_payload;
                    main_valid <= 1'b1;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (in_fire) begin
                skid_q <= s_payload;
            end
        end
    end

    assign s_ready   = in_ready;
    assign m_valid   = main_valid;
    assign m_payload = main_q;

endmodule

// File: rtl/sde_c2h_axis.sv
// C2H AXI-Stream ingress: skid-buffered forward to the data buffer, per-packet byte length
// on the last beat, and the C2H packet counter. Optional tkeep check: SDE_C2H_AXIS_KEEP_CHK_EN.
module sde_c2h_axis
    import sde_pkg::*;
#(
    parameter int DESC_TYPE       = 0,
    parameter int PCIM_DATA_WIDTH = 512,
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int USER_BIT_WIDTH  = (DESC_TYPE != 0) ? 1 : 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_axis_clr_pkt_cnt,
    output logic [31:0]           axis_cfg_pkt_cnt,
    output logic                  axis_cfg_keep_err,
    sde_c2h_axis_if.slave         c2h_axis,
    sde_c2h_axis_if.master        axis_buf,
    output logic [31:0]           axis_buf_len,
    output logic                  axis_wb_pkt_cnt_req,
    output logic [31:0]           axis_wb_pkt_cnt
);

    if (AXIS_DATA_WIDTH != SDE_AXIS_DW || PCIM_DATA_WIDTH != SDE_AXIS_DW ||
        (DESC_TYPE != 0 && DESC_TYPE != 1) ||
        USER_BIT_WIDTH < 1 || USER_BIT_WIDTH > SDE_USER_MAX) begin : g_cfg_check
        $error("sde_c2h_axis: unsupported parameter combination");
    end

    sde_beat_t   in_beat;
    sde_beat_t   out_beat;
    logic        in_fire;
    logic        buf_last_fire;
    logic [31:0] acc;
    logic [31:0] acc_next;
    logic [31:0] pkt_cnt;
    logic        wb_req;

    assign in_fire       = c2h_axis.valid & c2h_axis.ready;
    assign buf_last_fire = axis_buf.valid & axis_buf.ready & axis_buf.last;
    assign acc_next      = acc + 32'(sde_popcount(c2h_axis.keep));

    always_comb begin
        in_beat      = '0;
        in_beat.data = c2h_axis.data;
        in_beat.keep = c2h_axis.keep;
        in_beat.user = SDE_USER_MAX'(c2h_axis.user);
        in_beat.last = c2h_axis.last;
        in_beat.len  = acc_next;
    end

    sde_axis_skid #(
        .WIDTH($bits(sde_beat_t))
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (c2h_axis.valid),
        .s_ready   (c2h_axis.ready),
        .s_payload (in_beat),
        .m_valid   (axis_buf.valid),
        .m_ready   (axis_buf.ready),
        .m_payload (out_beat)
    );

    assign axis_buf.data = out_beat.data;
    assign axis_buf.keep = out_beat.keep;
    assign axis_buf.user = out_beat.user[USER_BIT_WIDTH-1:0];
    assign axis_buf.last = out_beat.last;
    assign axis_buf_len  = out_beat.len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (in_fire) begin
            acc <= c2h_axis.last ? '0 : acc_next;
        end
    end

    // Clear wins over a coincident last handshake; the write-back pulse still fires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
            wb_req  <= 1'b0;
        end else begin
            wb_req <= buf_last_fire;
            if (cfg_axis_clr_pkt_cnt) begin
                pkt_cnt <= '0;
            end else if (buf_last_fire) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end

    assign axis_cfg_pkt_cnt    = pkt_cnt;
    assign axis_wb_pkt_cnt     = pkt_cnt;
    assign axis_wb_pkt_cnt_req = wb_req;

`ifdef SDE_C2H_AXIS_KEEP_CHK_EN
    logic keep_bad;
    logic keep_err;

    assign keep_bad = c2h_axis.last ? ~sde_keep_contig(c2h_axis.keep)
                                    : (c2h_axis.keep != '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keep_err <= 1'b0;
        end else if (cfg_axis_clr_pkt_cnt) begin
            keep_err <= 1'b0;
        end else if (in_fire && keep_bad) begin
            keep_err <= 1'b1;
        end
    end

    assign axis_cfg_keep_err = keep_err;
`else
    assign axis_cfg_keep_err = 1'b0;
`endif

endmodule

// File: tb/tb_sde_c2h_axis.sv
// Directed, table-driven bench for sde_c2h_axis plus hand sequences for throughput, wrap and reset.
module tb_sde_c2h_axis;

`ifdef SDE_C2H_AXIS_KEEP_CHK_EN
    localparam logic KCHK = 1'b1;
`else
    localparam logic KCHK = 1'b0;
`endif
    localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] cfg_cnt;
    logic        kerr;
    logic [31:0] buf_len;
    logic        wb_req;
    logic [31:0] wb_cnt;

    int checks = 0;
    int errors = 0;

    sde_c2h_axis_if #(.USER_BIT_WIDTH(64)) c2h_if ();
    sde_c2h_axis_if #(.USER_BIT_WIDTH(64)) buf_if ();

    sde_c2h_axis #(
        .DESC_TYPE       (0),
        .PCIM_DATA_WIDTH (512),
        .AXIS_DATA_WIDTH (512),
        .USER_BIT_WIDTH  (64)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cfg_axis_clr_pkt_cnt (clr),
        .axis_cfg_pkt_cnt     (cfg_cnt),
        .axis_cfg_keep_err    (kerr),
        .c2h_axis             (c2h_if),
        .axis_buf             (buf_if),
        .axis_buf_len         (buf_len),
        .axis_wb_pkt_cnt_req  (wb_req),
        .axis_wb_pkt_cnt      (wb_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        vin;
        logic        lst;
        logic [63:0] keep;
        logic [7:0]  tag;
        logic        rdy;
        logic        clr;
        logic        e_crdy;
        logic        e_bv;
        logic        e_last;
        logic [7:0]  e_tag;
        logic [31:0] e_len;
        logic [31:0] e_cnt;
        logic        e_req;
        logic        e_kerr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic vin, input logic lst, input logic [63:0] keep,
                                input logic [7:0] tag, input logic rdy, input logic c,
                                input logic e_crdy, input logic e_bv, input logic e_last,
                                input logic [7:0] e_tag, input logic [31:0] e_len,
                                input logic [31:0] e_cnt, input logic e_req, input logic e_kerr);
        vec_t v;
        v.vin = vin; v.lst = lst; v.keep = keep; v.tag = tag; v.rdy = rdy; v.clr = c;
        v.e_crdy = e_crdy; v.e_bv = e_bv; v.e_last = e_last; v.e_tag = e_tag;
        v.e_len = e_len; v.e_cnt = e_cnt; v.e_req = e_req; v.e_kerr = e_kerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic [63:0] k,
                         input logic [7:0] t, input logic r, input logic c);
        c2h_if.valid = v;
        c2h_if.last  = l;
        c2h_if.keep  = k;
        c2h_if.data  = {64{t}};
        c2h_if.user  = {56'h0, t};
        buf_if.ready = r;
        clr          = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bubbles;

        drive(0, 0, 64'h0, 8'h00, 1'b1, 1'b0);
        #2;
        chk("reset c2h_ready", 512'(c2h_if.ready), 512'(0));
        chk("reset buf_valid", 512'(buf_if.valid), 512'(0));
        chk("reset pkt_cnt",   512'(cfg_cnt), 512'(0));
        chk("reset wb_req",    512'(wb_req), 512'(0));
        chk("reset keep_err",  512'(kerr), 512'(0));
        chk("reset len",       512'(buf_len), 512'(0));
        #20 rst_n = 1'b1;
        step();

        // vin lst keep tag rdy clr | crdy bv last tag len cnt req kerr
        tbl.push_back(mk(1, 1, ALL,   8'h01, 1, 0,  1, 0, 0, 8'h00,   0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 64'h0, 8'h00, 1, 0,  1, 1, 1, 8'h01,  64, 0, 0, 0));
        tbl.push_back(mk(0, 0, 64'h0, 8'h00, 1, 0,  1, 0, 0, 8'h00,   0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 64'h0, 8'h00, 1, 0,  1, 0, 0, 8'h00,   0, 1, 0, 0));
        tbl.push_back(mk(1, 0, ALL,   8'h02, 1, 0,  1, 0, 0, 8'h00,   0, 1, 0, 0));
        tbl.push_back(mk(1, 0, ALL,   8'h03, 1, 0,  1, 1, 0, 8'h02,   0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 64'hFF,8'h04, 1, 0,  1, 1, 0, 8'h03,   0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 64'h0, 8'h00, 1, 0,  1, 1, 1, 8'h04, 136, 1, 0, 0));
        tbl.push_back(mk(0, 0, 64'h0, 8'h00, 1, 0,  1, 0, 0, 8'h00,   0, 2, 1, 0));
        // backpressure: ready low for five cycles mid-packet
        tbl.push_back(mk(1, 0, ALL,   8'h10, 1, 0,  1, 0, 0, 8'h00,   0, 2, 0, 0));
        tbl.push_back(mk(1, 0, ALL,   8'h11, 0, 0,  1, 1, 0, 8'h10,   0, 2, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 0, ALL, 8'h12, 0, 0,  0, 1, 0, 8'h10,   0, 2, 0, 0));
        tbl.push_back(mk(1, 0, ALL,   8'h12, 1, 0,  0, 1, 0, 8'h10,   0, 2, 0, 0));
        tbl.push_back(mk(1, 0, ALL,   8'h12, 1, 0,  1, 1, 0, 8'h11,   0, 2, 0, 0));
        tbl.push_back(mk(1, 0, ALL,   8'h13, 1, 0,  1, 1, 0, 8'h12,   0, 2, 0, 0));
        tbl.push_back(mk(1, 0, ALL,   8'h14, 1, 0,  1, 1, 0, 8'h13,   0, 2, 0, 0));
        tbl.push_back(mk(1, 0, ALL,   8'h15, 1, 0,  1, 1, 0, 8'h14,   0, 2, 0, 0));
        tbl.push_back(mk(1, 1, ALL,   8'h16, 1, 0,  1, 1, 0, 8'h15,   0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 64'h0, 8'h00, 1, 0,  1, 1, 1, 8'h16, 448, 2, 0, 0));
        tbl.push_back(mk(0, 0, 64'h0, 8'h00, 1, 0,  1, 0, 0, 8'h00,   0, 3, 1, 0));
        // clear coincident with a last handshake
        tbl.push_back(mk(1, 1, 64'h0F,8'h20, 1, 0,  1, 0, 0, 8'h00,   0, 3, 0, 0));
        tbl.push_back(mk(0, 0, 64'h0, 8'h00, 1, 1,  1, 1, 1, 8'h20,   4, 3, 0, 0));
        tbl.push_back(mk(0, 0, 64'h0, 8'h00, 1, 0,  1, 0, 0, 8'h00,   0, 0, 1, 0));
        // zero-keep beat contributes no bytes
        tbl.push_back(mk(1, 0, 64'h0, 8'h21, 1, 0,  1, 0, 0, 8'h00,   0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 64'h1, 8'h22, 1, 0,  1, 1, 0, 8'h21,   0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 64'h0, 8'h00, 1, 0,  1, 1, 1, 8'h22,   1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 64'h0, 8'h00, 1, 0,  1, 0, 0, 8'h00,   0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 64'h0, 8'h00, 1, 1,  1, 0, 0, 8'h00,   0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 64'h0, 8'h00, 1, 0,  1, 0, 0, 8'h00,   0, 0, 0, 0));
        // short non-last keep
        tbl.push_back(mk(1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 8'h23, 1, 0,  1, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, ALL,   8'h24, 1, 0,  1, 1, 0, 8'h23,   0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 64'h0, 8'h00, 1, 0,  1, 1, 1, 8'h24, 127, 0, 0, 1));
        tbl.push_back(mk(0, 0, 64'h0, 8'h00, 1, 0,  1, 0, 0, 8'h00,   0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 64'h0, 8'h00, 1, 1,  1, 0, 0, 8'h00,   0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 64'h0, 8'h00, 1, 0,  1, 0, 0, 8'h00,   0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].vin, tbl[i].lst, tbl[i].keep, tbl[i].tag, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("v%0d c2h_ready", i), 512'(c2h_if.ready), 512'(tbl[i].e_crdy));
            chk($sformatf("v%0d buf_valid", i), 512'(buf_if.valid), 512'(tbl[i].e_bv));
            if (tbl[i].e_bv) begin
                chk($sformatf("v%0d buf_last", i), 512'(buf_if.last), 512'(tbl[i].e_last));
                chk($sformatf("v%0d buf_data", i), buf_if.data, {64{tbl[i].e_tag}});
                if (tbl[i].e_last)
                    chk($sformatf("v%0d buf_len", i), 512'(buf_len), 512'(tbl[i].e_len));
            end
            chk($sformatf("v%0d pkt_cnt", i), 512'(cfg_cnt), 512'(tbl[i].e_cnt));
            chk($sformatf("v%0d wb_cnt", i), 512'(wb_cnt), 512'(tbl[i].e_cnt));
            chk($sformatf("v%0d wb_req", i), 512'(wb_req), 512'(tbl[i].e_req));
            chk($sformatf("v%0d keep_err", i), 512'(kerr), 512'(tbl[i].e_kerr & KCHK));
            step();
        end

        // 100 back-to-back single-beat packets
        bubbles = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1, 1, ALL, 8'(i), 1, 0);
            if (i > 0 && !(buf_if.valid === 1'b1 && buf_if.data === {64{8'(i - 1)}} &&
                           c2h_if.ready === 1'b1))
                bubbles++;
            step();
        end
        drive(0, 0, 64'h0, 8'h00, 1, 0);
        chk("b2b bubbles", 512'(bubbles), 512'(0));
        chk("b2b last data", buf_if.data, {64{8'd99}});
        chk("b2b last len", 512'(buf_len), 512'(64));
        step();
        chk("b2b pkt_cnt", 512'(cfg_cnt), 512'(100));
        chk("b2b wb_req", 512'(wb_req), 512'(1));
        step();

        // counter wrap
        force dut.pkt_cnt = 32'hFFFF_FFFF;
        #1 release dut.pkt_cnt;
        chk("wrap preload", 512'(cfg_cnt), 512'(32'hFFFF_FFFF));
        drive(1, 1, ALL, 8'h30, 1, 0);
        step();
        drive(0, 0, 64'h0, 8'h00, 1, 0);
        chk("wrap buf_valid", 512'(buf_if.valid), 512'(1));
        step();
        chk("wrap pkt_cnt", 512'(cfg_cnt), 512'(0));
        chk("wrap wb_cnt", 512'(wb_cnt), 512'(0));
        chk("wrap wb_req", 512'(wb_req), 512'(1));
        drive(1, 1, ALL, 8'h31, 1, 0);
        step();
        drive(0, 0, 64'h0, 8'h00, 1, 0);
        step();
        chk("post-wrap pkt_cnt", 512'(cfg_cnt), 512'(1));

        // async reset with two beats of a partial packet buffered
        drive(1, 0, ALL, 8'h40, 0, 0);
        step();
        drive(1, 0, ALL, 8'h41, 0, 0);
        step();
        drive(0, 0, 64'h0, 8'h00, 0, 0);
        chk("pre-rst buf_valid", 512'(buf_if.valid), 512'(1));
        chk("pre-rst c2h_ready", 512'(c2h_if.ready), 512'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("rst buf_valid", 512'(buf_if.valid), 512'(0));
        chk("rst c2h_ready", 512'(c2h_if.ready), 512'(0));
        chk("rst pkt_cnt", 512'(cfg_cnt), 512'(0));
        chk("rst wb_req", 512'(wb_req), 512'(0));
        chk("rst buf_data", buf_if.data, 512'(0));
        #4 rst_n = 1'b1;
        step();
        chk("post-rst c2h_ready", 512'(c2h_if.ready), 512'(1));
        drive(1, 1, 64'h3, 8'h42, 1, 0);
        step();
        drive(0, 0, 64'h0, 8'h00, 1, 0);
        chk("post-rst buf_valid", 512'(buf_if.valid), 512'(1));
        chk("post-rst data", buf_if.data, {64{8'h42}});
        chk("post-rst len", 512'(buf_len), 512'(2));
        step();
        chk("post-rst pkt_cnt", 512'(cfg_cnt), 512'(1));
        chk("post-rst wb_req", 512'(wb_req), 512'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
